// File: rtl/cnn_layer_accel_weight_table_ctrl.sv
// rtl/cnn_layer_accel_weight_table_ctrl.sv - per-CE weight table job sequencer
// Loads one table of kernels from a valid/ready stream, then paces the execute passes.
module cnn_layer_accel_weight_table_ctrl #(
  parameter int C_WEIGHT_WIDTH     = 16,
  parameter int C_KERNEL_WORDS     = 9,
  parameter int C_CLG2_MAX_KERNELS = 6,
  parameter int C_PIX_CNT_WIDTH    = 16
) (
  input  logic                          clk_core,
  input  logic                          rst_n,
  input  logic                          job_start,
  input  logic                          job_abort,
  input  logic [C_CLG2_MAX_KERNELS-1:0] num_kernels,
  input  logic [C_PIX_CNT_WIDTH-1:0]    num_pix,
  input  logic                          wht_in_valid,
  input  logic [C_WEIGHT_WIDTH-1:0]     wht_in_data,
  output logic                          wht_in_ready,
  input  logic                          exec_stall,
  output logic                          config_mode,
  output logic                          job_accept,
  output logic                          wht_config_wren,
  output logic [C_WEIGHT_WIDTH-1:0]     wht_config_data,
  output logic                          ce_execute,
  output logic                          next_kernel,
  output logic                          busy,
  output logic                          job_done
);

  localparam int C_WORD_CNT_W = (C_KERNEL_WORDS > 1) ? $clog2(C_KERNEL_WORDS) : 1;
  localparam logic [C_WORD_CNT_W-1:0] C_WORD_LAST = C_WORD_CNT_W'(C_KERNEL_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_EXEC,
    S_DONE
  } state_t;

  state_t                          r_state;
  logic [C_CLG2_MAX_KERNELS-1:0]   r_num_kernels;
  logic [C_PIX_CNT_WIDTH-1:0]      r_num_pix;
  logic [C_WORD_CNT_W-1:0]         r_word_cnt;
  logic [C_CLG2_MAX_KERNELS-1:0]   r_kernel_cnt;
  logic [C_PIX_CNT_WIDTH-1:0]      r_pix_cnt;
  logic [C_CLG2_MAX_KERNELS-1:0]   r_pass_cnt;
  logic                            r_load_fin;
  logic                            r_wht_in_ready;
  logic                            r_config_mode;
  logic                            r_job_accept;
  logic                            r_wren;
  logic [C_WEIGHT_WIDTH-1:0]       r_wdata;
  logic                            r_busy;
  logic                            r_job_done;

  logic w_hs;
  logic w_word_last;
  logic w_kernel_last;
  logic w_exec;
  logic w_pix_last;
  logic w_pass_last;

  assign w_hs          = wht_in_valid && r_wht_in_ready;
  assign w_word_last   = (r_word_cnt == C_WORD_LAST);
  assign w_kernel_last = (r_kernel_cnt == r_num_kernels);
  assign w_exec        = (r_state == S_EXEC) && !exec_stall;
  assign w_pix_last    = (r_pix_cnt == r_num_pix - 1'b1);
  assign w_pass_last   = (r_pass_cnt == r_num_kernels);

  always_ff @(posedge clk_core or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_num_kernels  <= '0;
      r_num_pix      <= '0;
      r_word_cnt     <= '0;
      r_kernel_cnt   <= '0;
      r_pix_cnt      <= '0;
      r_pass_cnt     <= '0;
      r_load_fin     <= 1'b0;
      r_wht_in_ready <= 1'b0;
      r_config_mode  <= 1'b0;
      r_job_accept   <= 1'b0;
      r_wren         <= 1'b0;
      r_wdata        <= '0;
      r_busy         <= 1'b0;
      r_job_done     <= 1'b0;
    end else begin
      r_job_accept <= 1'b0;
      r_job_done   <= 1'b0;
      // A word accepted on the final handshake is always written, even under abort.
      r_wren       <= w_hs;
      if (w_hs) begin
        r_wdata <= wht_in_data;
      end

      case (r_state)
        S_IDLE: begin
          if (job_start && !job_abort) begin
            r_state       <= S_LOAD;
            r_num_kernels <= num_kernels;
            r_num_pix     <= num_pix;
            r_word_cnt    <= '0;
            r_kernel_cnt  <= '0;
            r_pix_cnt     <= '0;
            r_pass_cnt    <= '0;
            r_load_fin    <= 1'b0;
            r_job_accept  <= 1'b1;
            r_config_mode <= 1'b1;
            r_busy        <= 1'b1;
          end
        end

        S_LOAD: begin
          if (r_job_accept) begin
            r_wht_in_ready <= 1'b1;
          end
          if (w_hs) begin
            if (w_word_last) begin
              r_word_cnt <= '0;
              if (w_kernel_last) begin
                r_wht_in_ready <= 1'b0;
                r_load_fin     <= 1'b1;
              end else begin
                r_kernel_cnt <= r_kernel_cnt + 1'b1;
              end
            end else begin
              r_word_cnt <= r_word_cnt + 1'b1;
            end
          end
          // Leave config mode only after the last write strobe has been presented.
          if (r_load_fin) begin
            r_state       <= S_EXEC;
            r_config_mode <= 1'b0;
            r_load_fin    <= 1'b0;
          end
        end

        S_EXEC: begin
          if (!exec_stall) begin
            if (w_pix_last) begin
              r_pix_cnt <= '0;
              if (w_pass_last) begin
                r_state    <= S_DONE;
                r_job_done <= 1'b1;
              end else begin
                r_pass_cnt <= r_pass_cnt + 1'b1;
              end
            end else begin
              r_pix_cnt <= r_pix_cnt + 1'b1;
            end
          end
        end

        S_DONE: begin
          r_state      <= S_IDLE;
          r_busy       <= 1'b0;
          r_word_cnt   <= '0;
          r_kernel_cnt <= '0;
          r_pix_cnt    <= '0;
          r_pass_cnt   <= '0;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase

      if (job_abort && (r_state != S_IDLE)) begin
        r_state        <= S_IDLE;
        r_word_cnt     <= '0;
        r_kernel_cnt   <= '0;
        r_pix_cnt      <= '0;
        r_pass_cnt     <= '0;
        r_load_fin     <= 1'b0;
        r_wht_in_ready <= 1'b0;
        r_config_mode  <= 1'b0;
        r_job_accept   <= 1'b0;
        r_busy         <= 1'b0;
        r_job_done     <= 1'b0;
      end
    end
  end

  assign wht_in_ready    = r_wht_in_ready;
  assign config_mode     = r_config_mode;
  assign job_accept      = r_job_accept;
  assign wht_config_wren = r_wren;
  assign wht_config_data = r_wdata;
  assign busy            = r_busy;
  assign job_done        = r_job_done;
  // Execute strobes follow the stall input in the same cycle.
  assign ce_execute      = w_exec;
  assign next_kernel     = w_exec && w_pix_last;

endmodule

// File: tb/tb_cnn_layer_accel_weight_table_ctrl.sv
// tb/tb_cnn_layer_accel_weight_table_ctrl.sv - directed/random bench for the weight table controller
// Reference expectations come from job-level arithmetic: word order, counts and pass positions.
module tb_cnn_layer_accel_weight_table_ctrl;

  localparam int C_KW = 9;

  logic        clk_core;
  logic        rst_n;
  logic        job_start;
  logic        job_abort;
  logic [5:0]  num_kernels;
  logic [15:0] num_pix;
  logic        wht_in_valid;
  logic [15:0] wht_in_data;
  logic        wht_in_ready;
  logic        exec_stall;
  logic        config_mode;
  logic        job_accept;
  logic        wht_config_wren;
  logic [15:0] wht_config_data;
  logic        ce_execute;
  logic        next_kernel;
  logic        busy;
  logic        job_done;

  cnn_layer_accel_weight_table_ctrl #(
    .C_WEIGHT_WIDTH    (16),
    .C_KERNEL_WORDS    (C_KW),
    .C_CLG2_MAX_KERNELS(6),
    .C_PIX_CNT_WIDTH   (16)
  ) dut (
    .clk_core       (clk_core),
    .rst_n          (rst_n),
    .job_start      (job_start),
    .job_abort      (job_abort),
    .num_kernels    (num_kernels),
    .num_pix        (num_pix),
    .wht_in_valid   (wht_in_valid),
    .wht_in_data    (wht_in_data),
    .wht_in_ready   (wht_in_ready),
    .exec_stall     (exec_stall),
    .config_mode    (config_mode),
    .job_accept     (job_accept),
    .wht_config_wren(wht_config_wren),
    .wht_config_data(wht_config_data),
    .ce_execute     (ce_execute),
    .next_kernel    (next_kernel),
    .busy           (busy),
    .job_done       (job_done)
  );

  initial begin
    clk_core = 1'b0;
    forever #5 clk_core = ~clk_core;
  end

  int n_checks = 0;
  int n_err    = 0;

  logic [15:0] words[$];
  logic        mon_clr = 1'b0;

  // Passive recorder, sampled on the falling edge.
  logic [15:0] wren_q[$];
  int          nk_q[$];
  int mon_cyc = 0, start_cyc = -1, accept_cnt = 0, accept_cyc = -1;
  int last_wren_cyc = -1, wren_cfg = 0, cfg_fall_cyc = -1;
  int act_cnt = 0, last_nk_cyc = -1, done_cnt = 0, done_cyc = -1, ce_bad = 0;
  logic prev_cfg = 1'b0;

  initial begin
    forever begin
      @(negedge clk_core);
      if (mon_clr) begin
        wren_q.delete();
        nk_q.delete();
        start_cyc = -1; accept_cnt = 0; accept_cyc = -1;
        last_wren_cyc = -1; wren_cfg = 0; cfg_fall_cyc = -1;
        act_cnt = 0; last_nk_cyc = -1; done_cnt = 0; done_cyc = -1; ce_bad = 0;
      end
      mon_cyc++;
      if (job_start && !busy && !job_abort && rst_n) start_cyc = mon_cyc;
      if (job_accept) begin accept_cnt++; accept_cyc = mon_cyc; end
      if (wht_config_wren) begin
        wren_q.push_back(wht_config_data);
        last_wren_cyc = mon_cyc;
        if (config_mode) wren_cfg++;
      end
      if (prev_cfg && !config_mode) cfg_fall_cyc = mon_cyc;
      prev_cfg = config_mode;
      if (ce_execute && (exec_stall || config_mode || !busy)) ce_bad++;
      if (next_kernel && !ce_execute) ce_bad++;
      if (ce_execute) act_cnt++;
      if (next_kernel) begin nk_q.push_back(act_cnt); last_nk_cyc = mon_cyc; end
      if (job_done) begin done_cnt++; done_cyc = mon_cyc; end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic gen_words(input int total);
    words.delete();
    for (int i = 0; i < total; i++) words.push_back(16'($urandom));
  endtask

  task automatic start_job(input int nk, input int np);
    @(posedge clk_core); #1;
    job_start = 1'b1; num_kernels = 6'(nk); num_pix = 16'(np); mon_clr = 1'b1;
    @(negedge clk_core);
    chk("idle_before_start", 32'(busy), 0);
    @(posedge clk_core); #1;
    job_start = 1'b0; mon_clr = 1'b0;
    num_kernels = 6'($urandom); num_pix = 16'($urandom);
    @(negedge clk_core);
    chk("job_accept", 32'(job_accept), 1);
    chk("config_on_accept", 32'(config_mode), 1);
    chk("ready_off_on_accept", 32'(wht_in_ready), 0);
    chk("busy_on_accept", 32'(busy), 1);
  endtask

  // Offers words in order until n_stop handshakes have been seen.
  task automatic load_words(input int n_stop, input int vmode);
    int idx, cyc;
    logic v;
    idx = 0; cyc = 0;
    while (idx < n_stop && cyc < 3000) begin
      @(posedge clk_core); #1;
      if (vmode == 0)      v = 1'b1;
      else if (vmode == 1) v = ((cyc % 2) == 1);
      else                 v = 1'($urandom_range(0, 1));
      wht_in_valid = v;
      wht_in_data  = v ? words[idx] : 16'($urandom);
      @(negedge clk_core);
      if (v && wht_in_ready) idx++;
      cyc++;
    end
    chk("load_words_accepted", idx, n_stop);
  endtask

  task automatic run_job(input int nk, input int np, input int vmode, input int smode);
    int total, ec, stalls, n;
    bit done_seen;
    total = C_KW * (nk + 1);
    gen_words(total);
    start_job(nk, np);
    load_words(total, vmode);
    @(posedge clk_core); #1;
    wht_in_valid = 1'b0;
    @(negedge clk_core);
    chk("ready_drop_after_last", 32'(wht_in_ready), 0);
    chk("last_wren", 32'(wht_config_wren), 1);
    chk("config_during_last_wren", 32'(config_mode), 1);

    ec = 0; stalls = 0; done_seen = 1'b0;
    while (!done_seen && ec < 3000) begin
      @(posedge clk_core); #1;
      if (smode == 0)      exec_stall = 1'b0;
      else if (smode == 1) exec_stall = ($urandom_range(0, 3) == 0);
      else                 exec_stall = (ec == 1 || ec == 2);
      job_start   = ($urandom_range(0, 7) == 0);
      num_kernels = 6'($urandom);
      @(negedge clk_core);
      if (job_done) done_seen = 1'b1;
      else begin
        if (exec_stall) stalls++;
        ec++;
      end
    end
    chk("job_done_seen", 32'(done_seen), 1);
    chk("exec_length", ec, (nk + 1) * np + stalls);

    @(posedge clk_core); #1;
    exec_stall = 1'b0; job_start = 1'b0;
    @(negedge clk_core);
    chk("idle_after_done", 32'(busy), 0);
    chk("done_single_pulse", 32'(job_done), 0);
    @(posedge clk_core); #1;

    chk("accept_count", accept_cnt, 1);
    chk("accept_latency", accept_cyc, start_cyc + 1);
    chk("wren_count", wren_q.size(), total);
    n = (wren_q.size() < total) ? wren_q.size() : total;
    for (int i = 0; i < n; i++) chk($sformatf("wren_data[%0d]", i), 32'(wren_q[i]), 32'(words[i]));
    chk("wren_in_config", wren_cfg, total);
    chk("config_fall", cfg_fall_cyc, last_wren_cyc + 1);
    chk("next_kernel_count", nk_q.size(), nk + 1);
    for (int i = 0; i < nk_q.size() && i <= nk; i++)
      chk($sformatf("next_kernel_pos[%0d]", i), nk_q[i], (i + 1) * np);
    chk("exec_active_cycles", act_cnt, (nk + 1) * np);
    chk("done_count", done_cnt, 1);
    chk("done_after_last_kernel", done_cyc, last_nk_cyc + 1);
    chk("ce_execute_rules", ce_bad, 0);
  endtask

  initial begin
    rst_n = 1'b0; job_start = 1'b0; job_abort = 1'b0;
    num_kernels = '0; num_pix = '0; wht_in_valid = 1'b0; wht_in_data = '0; exec_stall = 1'b0;

    repeat (3) @(posedge clk_core);
    @(negedge clk_core);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_config", 32'(config_mode), 0);
    chk("rst_ready", 32'(wht_in_ready), 0);
    chk("rst_wren", 32'(wht_config_wren), 0);
    chk("rst_data", 32'(wht_config_data), 0);
    chk("rst_ce", 32'(ce_execute), 0);
    chk("rst_done", 32'(job_done), 0);
    chk("rst_accept", 32'(job_accept), 0);
    @(posedge clk_core); #1;
    rst_n = 1'b1;

    run_job(1, 4, 0, 0);
    run_job(0, $urandom_range(1, 5), 1, 0);
    run_job(2, 3, 0, 2);
    run_job(3, 1, 0, 0);

    // Abort after word 5 of kernel 0, then restart.
    gen_words(C_KW * 2);
    start_job(1, 2);
    load_words(6, 0);
    @(posedge clk_core); #1;
    wht_in_valid = 1'b0; job_abort = 1'b1;
    @(negedge clk_core);
    chk("abort_pre_busy", 32'(busy), 1);
    @(posedge clk_core); #1;
    job_abort = 1'b0;
    @(negedge clk_core);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_config", 32'(config_mode), 0);
    chk("abort_ready", 32'(wht_in_ready), 0);
    chk("abort_ce", 32'(ce_execute), 0);
    repeat (5) @(negedge clk_core);
    @(posedge clk_core); #1;
    chk("abort_no_done", done_cnt, 0);
    chk("abort_wren_count", wren_q.size(), 6);
    run_job(1, 2, 0, 0);

    // Start and abort together in IDLE: abort wins.
    @(posedge clk_core); #1;
    job_start = 1'b1; job_abort = 1'b1; num_kernels = 6'd0; num_pix = 16'd1;
    @(posedge clk_core); #1;
    job_start = 1'b0; job_abort = 1'b0;
    @(negedge clk_core);
    chk("start_abort_busy", 32'(busy), 0);
    chk("start_abort_accept", 32'(job_accept), 0);
    chk("start_abort_config", 32'(config_mode), 0);

    for (int r = 0; r < 3; r++) run_job($urandom_range(0, 3), $urandom_range(1, 6), 2, 1);

    // Asynchronous reset in the middle of execute.
    gen_words(C_KW);
    start_job(0, 20);
    load_words(C_KW, 0);
    @(posedge clk_core); #1;
    wht_in_valid = 1'b0;
    repeat (3) @(posedge clk_core);
    #3;
    chk("pre_reset_ce", 32'(ce_execute), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_ce", 32'(ce_execute), 0);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_config", 32'(config_mode), 0);
    chk("async_rst_next_kernel", 32'(next_kernel), 0);
    chk("async_rst_ready", 32'(wht_in_ready), 0);
    chk("async_rst_wren", 32'(wht_config_wren), 0);
    chk("async_rst_data", 32'(wht_config_data), 0);
    @(posedge clk_core); #1;
    rst_n = 1'b1;
    @(negedge clk_core);
    chk("post_reset_idle", 32'(busy), 0);
    chk("post_reset_ce", 32'(ce_execute), 0);
    run_job(0, 2, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/cnn_layer_accel_weight_table_ctrl.md
Name: cnn_layer_accel_weight_table_ctrl

Overview:
- Sequences one weight table per CE through a job: IDLE -> weight load -> execute -> done.
- Accepts a valid/ready weight stream and drives the table's config_mode, job_accept, wht_config_wren and wht_config_data.
- During execute, drives ce_execute and emits one next_kernel pulse per kernel pass.
- Sits between the QUAD job dispatcher and the weight table, one instance per CE.

Parameters:
- C_WEIGHT_WIDTH, 16, weight word width; must match the table config port.
- C_KERNEL_WORDS, 9, weights per 3x3 kernel (full-count minus 1 = 8).
- C_CLG2_MAX_KERNELS, 6, width of num_kernels and the kernel counter.
- C_PIX_CNT_WIDTH, 16, width of the per-kernel pixel count.

Ports:
- clk_core, in, 1, single core clock; all logic on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- job_start, in, 1, one-cycle start request; sampled only in IDLE.
- job_abort, in, 1, synchronous abort from any state.
- num_kernels, in, C_CLG2_MAX_KERNELS, index of last kernel (kernel count minus 1); latched at job_start.
- num_pix, in, C_PIX_CNT_WIDTH, execute cycles per kernel pass, must be >=1; latched at job_start.
- wht_in_valid, in, 1, upstream weight word valid.
- wht_in_data, in, C_WEIGHT_WIDTH, upstream weight word.
- wht_in_ready, out, 1, controller accepts a word this cycle.
- exec_stall, in, 1, freezes execute counting and ce_execute.
- config_mode, out, 1, table in config mode.
- job_accept, out, 1, one-cycle pulse that clears table counters.
- wht_config_wren, out, 1, table write strobe.
- wht_config_data, out, C_WEIGHT_WIDTH, table write data.
- ce_execute, out, 1, table read enable request.
- next_kernel, out, 1, one-cycle pulse at end of each kernel pass.
- busy, out, 1, high in any state except IDLE.
- job_done, out, 1, one-cycle pulse on job completion.

Behaviour:
- Reset (rst_n low, async): state = IDLE; all outputs 0; all counters 0; latched values 0.
- States are IDLE, LOAD, EXEC and DONE.
- IDLE -> LOAD:
  - On job_start, latch num_kernels and num_pix.
  - Next cycle: job_accept = 1 for one cycle; config_mode = 1 for the whole of LOAD.
- LOAD:
  - wht_in_ready = 1 from the cycle after job_accept through the handshake of the final word.
  - Handshake is wht_in_valid & wht_in_ready.
  - On each handshake, wht_config_wren = 1 and wht_config_data = wht_in_data on the next cycle (1-cycle registered latency); otherwise wren = 0.
  - word_cnt counts 0..8, then wraps to 0 and increments kernel_cnt.
  - valid low mid-kernel holds both counters; there are no gaps required between words.
  - After the handshake with word_cnt = 8 and kernel_cnt = latched num_kernels:
    - wht_in_ready drops the next cycle.
    - The state moves to EXEC one cycle after the final wren, so config_mode stays high through the last write.
- EXEC:
  - config_mode = 0.
  - ce_execute = !exec_stall.
  - pix_cnt increments on each non-stalled cycle.
  - When pix_cnt = num_pix-1 on a non-stalled cycle:
    - next_kernel = 1 for one cycle and pix_cnt wraps to 0.
    - pass_cnt increments; if pass_cnt = num_kernels, go to DONE instead.
  - Stall holds all counters and suppresses next_kernel.
  - num_pix = 1 yields next_kernel on every non-stalled cycle.
- DONE: job_done = 1 for one cycle, ce_execute = 0, then return to IDLE.
- job_start outside IDLE is ignored (no queuing).
- Simultaneous job_start and job_abort in IDLE: abort wins, the job is not started.
- job_abort in any non-IDLE state:
  - Next state is IDLE; config_mode, ce_execute and wht_in_ready drop the next cycle.
  - job_done is not pulsed; counters clear.
  - Any in-flight wren from the final handshake still completes.
- Counters are unsigned; kernel_cnt and pass_cnt never exceed the latched num_kernels.
- num_kernels = 0 gives a single kernel: 9 writes and one execute pass.
- Reset asserted mid-operation: outputs clear immediately (async); the table must be re-configured by a new job.

Test Plan:
- Basic job: num_kernels=1, num_pix=4, continuous valid.
  - job_accept 1 cycle after start; exactly 18 wrens, data in order.
  - config_mode falls after the 18th wren; ce_execute high 8 cycles.
  - next_kernel at exec cycles 4 and 8; job_done 1 cycle later.
- Bubbled load: num_kernels=0, wht_in_valid toggling every other cycle.
  - 9 wrens with matching data; word_cnt holds during gaps; no extra wren.
- Execute stall: num_kernels=2, num_pix=3, exec_stall high 2 cycles mid-pass.
  - ce_execute low during the stall; next_kernel delayed by 2 cycles; total 3 pulses.
- Edge counts: num_pix=1, num_kernels=3.
  - next_kernel on 4 consecutive cycles; job_done follows.
- Abort and restart: job_abort after word 5 of kernel 0.
  - IDLE next cycle, busy=0, no job_done.
  - A new job_start then produces a fresh job_accept and a full reload.
- Async reset: rst_n low during EXEC.
  - All outputs 0 with no clock edge; state is IDLE after release.
